// File: rtl/sevenseg_decoder.sv
// -----------------------------------------------------------------------------
// sevenseg_decoder
//
// Receive-side decoder for a multiplexed 7-segment display bus. The anode,
// segment (and optionally dot-point) lines are synchronized. Each scan slot
// must hold steady for STABLE_CYCLES cycles before it is captured. A captured
// pattern is decoded back into a hex digit for the slot selected by the
// one-hot anode enable. Used for board self-test and for loopback checking of
// the display driver.
//
// Parameters:
//   STABLE_CYCLES   cycles the synchronized bus must stay unchanged before a
//                   capture (>= 2)
//   TIMEOUT_CYCLES  cycles without a capture of a digit before its valid
//                   flag clears
//
// Optional feature macro: DP_CAPTURE_EN
//   defined   : dp is synchronized, takes part in the stability check, and is
//               captured into dp_out[upd_idx]
//   undefined : dp is ignored and dp_out is tied to 0
//
// Ports:
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset (release synchronized here)
//   seg[6:0]   in   segment lines {g,f,e,d,c,b,a}, active-high
//   dp         in   dot-point line, active-high
//   an[3:0]    in   one-hot anode enables, an[0] = units digit
//   dig0..dig3 out  recovered hex value per digit
//   valid[3:0] out  digit holds a fresh, legal decode
//   err[3:0]   out  last capture of the digit was an illegal pattern
//   upd        out  one-cycle pulse on every capture
//   upd_idx    out  digit index captured on the upd cycle
//   dp_out     out  captured dot-point per digit
// -----------------------------------------------------------------------------
module sevenseg_decoder #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 524288
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [6:0] seg,
  input  logic       dp,
  input  logic [3:0] an,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] valid,
  output logic [3:0] err,
  output logic       upd,
  output logic [1:0] upd_idx,
  output logic [3:0] dp_out
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
`ifdef DP_CAPTURE_EN
  localparam int BUS_W = 12;
`else
  localparam int BUS_W = 11;
`endif

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_e;

  // Reset: asserts asynchronously, releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Raw bus, packed as {[dp,] an, seg}.
  logic [BUS_W-1:0] bus_raw;
`ifdef DP_CAPTURE_EN
  assign bus_raw = {dp, an, seg};
`else
  logic unused_dp;
  assign unused_dp = dp;
  assign bus_raw   = {an, seg};
`endif

  // Two-flop synchronizer plus a one-cycle-delayed copy for change detection.
  logic [BUS_W-1:0] bus_m_q, bus_s_q, bus_p_q;

  logic [6:0] seg_s;
  logic [3:0] an_s;
  assign seg_s = bus_s_q[6:0];
  assign an_s  = bus_s_q[10:7];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q [4];
  logic [TMO_W-1:0] tmo_d [4];
  logic [3:0]       dig_q [4];
  logic [3:0]       dig_d [4];
  logic [3:0]       valid_q, valid_d;
  logic [3:0]       err_q, err_d;
  logic             upd_q, upd_d;
  logic [1:0]       upd_idx_q, upd_idx_d;
  logic [3:0]       dp_out_q, dp_out_d;

  logic       changed, onehot, capture;
  logic [1:0] idx;
  logic [4:0] dec;   // {legal, value}

  // Inverse of the hex segment table; anything else is illegal.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0111111: decode = {1'b1, 4'h0};
      7'b0000110: decode = {1'b1, 4'h1};
      7'b1011011: decode = {1'b1, 4'h2};
      7'b1001111: decode = {1'b1, 4'h3};
      7'b1100110: decode = {1'b1, 4'h4};
      7'b1101101: decode = {1'b1, 4'h5};
      7'b1111101: decode = {1'b1, 4'h6};
      7'b0000111: decode = {1'b1, 4'h7};
      7'b1111111: decode = {1'b1, 4'h8};
      7'b1101111: decode = {1'b1, 4'h9};
      7'b1110111: decode = {1'b1, 4'hA};
      7'b1111100: decode = {1'b1, 4'hB};
      7'b0111001: decode = {1'b1, 4'hC};
      7'b1011110: decode = {1'b1, 4'hD};
      7'b1111001: decode = {1'b1, 4'hE};
      7'b1110001: decode = {1'b1, 4'hF};
      default:    decode = 5'b0_0000;
    endcase
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    changed = (bus_s_q != bus_p_q);
    onehot  = (an_s != 4'b0000) && ((an_s & (an_s - 4'd1)) == 4'b0000);
    dec     = decode(seg_s);
    idx     = 2'd0;
    case (an_s)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase

    // Counter value k means the bus has been unchanged for k edges.
    if (changed)                                  cnt_d = '0;
    else if (cnt_q == CNT_W'(STABLE_CYCLES))      cnt_d = cnt_q;
    else                                          cnt_d = cnt_q + CNT_W'(1);

    capture = (state_q == SETTLE) && onehot && !changed &&
              (cnt_q == CNT_W'(STABLE_CYCLES - 1));

    state_d = state_q;
    case (state_q)
      IDLE:     if (onehot) state_d = SETTLE;
      SETTLE:   if (!onehot)     state_d = IDLE;
                else if (capture) state_d = CAPTURED;
      CAPTURED: if (changed) state_d = onehot ? SETTLE : IDLE;
      default:  state_d = IDLE;
    endcase

    upd_d     = capture;
    upd_idx_d = capture ? idx : upd_idx_q;
    valid_d   = valid_q;
    err_d     = err_q;
    dp_out_d  = dp_out_q;

    for (int i = 0; i < 4; i++) begin
      dig_d[i] = dig_q[i];
      if (capture && idx == 2'(i)) begin
        tmo_d[i] = '0;
        if (dec[4]) begin
          dig_d[i]   = dec[3:0];
          valid_d[i] = 1'b1;
          err_d[i]   = 1'b0;
        end else begin
          valid_d[i] = 1'b0;
          err_d[i]   = 1'b1;
        end
`ifdef DP_CAPTURE_EN
        dp_out_d[i] = bus_s_q[11];
`endif
      end else begin
        tmo_d[i] = (tmo_q[i] == TMO_W'(TIMEOUT_CYCLES)) ? tmo_q[i]
                                                         : tmo_q[i] + TMO_W'(1);
        // Stale digit: valid drops on the edge the counter reaches the limit.
        if (tmo_d[i] == TMO_W'(TIMEOUT_CYCLES)) valid_d[i] = 1'b0;
      end
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      bus_m_q   <= '0;
      bus_s_q   <= '0;
      bus_p_q   <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      valid_q   <= '0;
      err_q     <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
      dp_out_q  <= '0;
      // NOTE: the per-digit arrays are only four entries of flops, so they
      // are reset like any other register rather than treated as a RAM.
      for (int i = 0; i < 4; i++) begin
        dig_q[i] <= '0;
        tmo_q[i] <= '0;
      end
    end else begin
      bus_m_q   <= bus_raw;
      bus_s_q   <= bus_m_q;
      bus_p_q   <= bus_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      upd_q     <= upd_d;
      upd_idx_q <= upd_idx_d;
      dp_out_q  <= dp_out_d;
      for (int i = 0; i < 4; i++) begin
        dig_q[i] <= dig_d[i];
        tmo_q[i] <= tmo_d[i];
      end
    end
  end

  assign dig0    = dig_q[0];
  assign dig1    = dig_q[1];
  assign dig2    = dig_q[2];
  assign dig3    = dig_q[3];
  assign valid   = valid_q;
  assign err     = err_q;
  assign upd     = upd_q;
  assign upd_idx = upd_idx_q;
`ifdef DP_CAPTURE_EN
  assign dp_out  = dp_out_q;
`else
  assign dp_out  = 4'b0000;
`endif

endmodule
